// File: rtl/case2_stream_pkg.sv
// Shared defaults, widths and types for the case-2 H_row / alpha_u_col stream endpoints.
package case2_stream_pkg;

  localparam int J_DEF       = 14;
  localparam int I_DEF       = 7;
  localparam int A_DEF       = 2;
  localparam int ALPHA_W_DEF = 16;

  localparam int J_WIDTH = $clog2(J_DEF) + 1;
  localparam int I_WIDTH = $clog2(I_DEF) + 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;

  typedef logic [J_DEF-1:0]             h_row_t;
  typedef logic [A_DEF*ALPHA_W_DEF-1:0] alpha_col_t;

  // Saturating 16-bit accumulate used by the optional statistics counters.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/stream_frame_sink.sv
// One stream of a frame: beat counter, tready, storage, tlast framing check and
// registered indexed readback (1-cycle latency, out-of-range index reads zero).
module stream_frame_sink #(
  parameter int N  = 7,
  parameter int W  = 14,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [W-1:0]  in_dat,
  input  logic          in_vld,
  input  logic          in_last,
  output logic          in_rdy,
  output logic          full_nxt,
  output logic          err,
  input  logic [CW-1:0] rd_idx,
  output logic [W-1:0]  rd_dat
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  logic [W-1:0]  mem_q [N];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [W-1:0]  rd_dat_q, rd_dat_d;
  logic          beat;

  always_comb begin
    in_rdy = en && (cnt_q < N_C);
    beat   = in_rdy && in_vld;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
      // tlast must coincide exactly with the final beat index
      if (in_last != (cnt_q == LAST_C)) err_d = 1'b1;
    end
    full_nxt = (cnt_d == N_C);
    rd_dat_d = '0;
    if (rd_idx < N_C) rd_dat_d = mem_q[rd_idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (!rst && beat) mem_q[cnt_q[AW-1:0]] <= in_dat;
  end

  assign err    = err_q;
  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/h_alpha_stream_rx.sv
// Receive endpoint capturing one H / alpha_u frame with tlast checks and indexed readback.
// Optional RX_STATS_EN adds stat_cycles / stat_stalls RECV-phase counters.
module h_alpha_stream_rx
  import case2_stream_pkg::*;
#(
  parameter int J       = J_DEF,
  parameter int I       = I_DEF,
  parameter int A       = A_DEF,
  parameter int ALPHA_W = ALPHA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [J-1:0]           H_row,
  input  logic                   H_row_tvalid,
  input  logic                   H_row_tlast,
  output logic                   H_row_tready,
  input  logic [A*ALPHA_W-1:0]   alpha_u_col,
  input  logic                   alpha_u_col_tvalid,
  input  logic                   alpha_u_col_tlast,
  output logic                   alpha_u_col_tready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_valid,
  output logic                   err_h_last,
  output logic                   err_a_last,
  input  logic [$clog2(I):0]     rd_h_idx,
  output logic [J-1:0]           rd_h_row,
  input  logic [$clog2(J):0]     rd_a_idx,
  output logic [A*ALPHA_W-1:0]   rd_a_col
`ifdef RX_STATS_EN
  ,
  output logic [15:0]            stat_cycles,
  output logic [15:0]            stat_stalls
`endif
);

  localparam int J_W = $clog2(J) + 1;
  localparam int I_W = $clog2(I) + 1;

  rx_state_t state_q, state_d;
  logic      frame_done_q, frame_done_d;
  logic      frame_valid_q, frame_valid_d;
  logic      arm_go;
  logic      recv;
  logic      h_full_nxt, a_full_nxt;

  assign recv = (state_q == RECV);

  always_comb begin
    state_d       = state_q;
    frame_done_d  = 1'b0;
    frame_valid_d = frame_valid_q;
    arm_go        = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = RECV;
          arm_go  = 1'b1;
        end
      end
      RECV: begin
        // Frame ends on counts alone; tlast only feeds the error flags.
        if (h_full_nxt && a_full_nxt) begin
          state_d       = DONE;
          frame_done_d  = 1'b1;
          frame_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (arm) begin
          state_d       = RECV;
          arm_go        = 1'b1;
          frame_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_done_q  <= frame_done_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  stream_frame_sink #(.N(I), .W(J), .CW(I_W)) u_h_sink (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm_go),
    .en       (recv),
    .in_dat   (H_row),
    .in_vld   (H_row_tvalid),
    .in_last  (H_row_tlast),
    .in_rdy   (H_row_tready),
    .full_nxt (h_full_nxt),
    .err      (err_h_last),
    .rd_idx   (rd_h_idx),
    .rd_dat   (rd_h_row)
  );

  stream_frame_sink #(.N(J), .W(A*ALPHA_W), .CW(J_W)) u_a_sink (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm_go),
    .en       (recv),
    .in_dat   (alpha_u_col),
    .in_vld   (alpha_u_col_tvalid),
    .in_last  (alpha_u_col_tlast),
    .in_rdy   (alpha_u_col_tready),
    .full_nxt (a_full_nxt),
    .err      (err_a_last),
    .rd_idx   (rd_a_idx),
    .rd_dat   (rd_a_col)
  );

  assign busy        = recv;
  assign frame_done  = frame_done_q;
  assign frame_valid = frame_valid_q;

`ifdef RX_STATS_EN
  logic [15:0] stat_cycles_q, stat_cycles_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;
  logic [1:0]  stall_inc;

  always_comb begin
    stall_inc     = {1'b0, H_row_tready & ~H_row_tvalid}
                  + {1'b0, alpha_u_col_tready & ~alpha_u_col_tvalid};
    stat_cycles_d = stat_cycles_q;
    stat_stalls_d = stat_stalls_q;
    if (arm_go) begin
      stat_cycles_d = '0;
      stat_stalls_d = '0;
    end else if (recv) begin
      stat_cycles_d = sat_add16(stat_cycles_q, 2'd1);
      stat_stalls_d = sat_add16(stat_stalls_q, stall_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cycles_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_cycles_q <= stat_cycles_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_cycles = stat_cycles_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_h_alpha_stream_rx.sv
// Scoreboard bench for h_alpha_stream_rx: accepted beats are queued, readback pops and compares.
module tb_h_alpha_stream_rx;

  localparam int J = 14;
  localparam int I = 7;
  localparam int A = 2;
  localparam int ALPHA_W = 16;

  logic                 clk = 1'b0;
  logic                 rst, arm;
  logic [J-1:0]         H_row;
  logic                 H_row_tvalid, H_row_tlast, H_row_tready;
  logic [A*ALPHA_W-1:0] alpha_u_col;
  logic                 alpha_u_col_tvalid, alpha_u_col_tlast, alpha_u_col_tready;
  logic                 busy, frame_done, frame_valid, err_h_last, err_a_last;
  logic [3:0]           rd_h_idx;
  logic [J-1:0]         rd_h_row;
  logic [4:0]           rd_a_idx;
  logic [A*ALPHA_W-1:0] rd_a_col;
`ifdef RX_STATS_EN
  logic [15:0]          stat_cycles, stat_stalls;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [J-1:0]         h_q [$];
  logic [A*ALPHA_W-1:0] a_q [$];

  always #5 clk = ~clk;

  h_alpha_stream_rx #(.J(J), .I(I), .A(A), .ALPHA_W(ALPHA_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .arm                (arm),
    .H_row              (H_row),
    .H_row_tvalid       (H_row_tvalid),
    .H_row_tlast        (H_row_tlast),
    .H_row_tready       (H_row_tready),
    .alpha_u_col        (alpha_u_col),
    .alpha_u_col_tvalid (alpha_u_col_tvalid),
    .alpha_u_col_tlast  (alpha_u_col_tlast),
    .alpha_u_col_tready (alpha_u_col_tready),
    .busy               (busy),
    .frame_done         (frame_done),
    .frame_valid        (frame_valid),
    .err_h_last         (err_h_last),
    .err_a_last         (err_a_last),
    .rd_h_idx           (rd_h_idx),
    .rd_h_row           (rd_h_row),
    .rd_a_idx           (rd_a_idx),
    .rd_a_col           (rd_a_col)
`ifdef RX_STATS_EN
    ,
    .stat_cycles        (stat_cycles),
    .stat_stalls        (stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beats with junk data are presented during arm; they must not be accepted.
  task automatic arm_pulse();
    arm = 1'b1;
    H_row_tvalid = 1'b1;
    H_row = '1;
    alpha_u_col_tvalid = 1'b1;
    alpha_u_col = '1;
    @(negedge clk);
    arm = 1'b0;
    H_row_tvalid = 1'b0;
    alpha_u_col_tvalid = 1'b0;
  endtask

  task automatic send_h(input int n, input int last_at, input int gap_at, input int rmax);
    for (int r = 0; r < n; r++) begin
      int g;
      int t;
      g = (r == gap_at) ? 2 : 0;
      if (rmax > 0) g += int'($urandom_range(rmax, 0));
      H_row_tvalid = 1'b0;
      repeat (g) @(negedge clk);
      H_row = '0;
      H_row[r] = 1'b1;
      H_row_tlast = (r == last_at);
      H_row_tvalid = 1'b1;
      t = 0;
      while (!H_row_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("h_rdy_timeout", 64'd0, 64'd1);
      else h_q.push_back(H_row);
      @(negedge clk);
    end
    H_row_tvalid = 1'b0;
    H_row_tlast = 1'b0;
  endtask

  task automatic send_a(input int n, input int last_at, input int gap_at, input int rmax);
    for (int c = 0; c < n; c++) begin
      int g;
      int t;
      g = (c == gap_at) ? 2 : 0;
      if (rmax > 0) g += int'($urandom_range(rmax, 0));
      alpha_u_col_tvalid = 1'b0;
      repeat (g) @(negedge clk);
      alpha_u_col = {16'(c), 16'(-c)};
      alpha_u_col_tlast = (c == last_at);
      alpha_u_col_tvalid = 1'b1;
      t = 0;
      while (!alpha_u_col_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("a_rdy_timeout", 64'd0, 64'd1);
      else a_q.push_back(alpha_u_col);
      @(negedge clk);
    end
    alpha_u_col_tvalid = 1'b0;
    alpha_u_col_tlast = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!frame_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_rise", frame_done, 1);
    chk("valid_at_done", frame_valid, 1);
    chk("busy_at_done", busy, 0);
    chk("treadys_at_done", {H_row_tready, alpha_u_col_tready}, 0);
    @(negedge clk);
    chk("done_one_cycle", frame_done, 0);
    chk("valid_held", frame_valid, 1);
  endtask

  task automatic readback_all();
    for (int k = 0; k < J; k++) begin
      rd_a_idx = 5'(k);
      if (k < I) rd_h_idx = 4'(k);
      @(negedge clk);
      if (k < I) begin
        if (h_q.size() == 0) chk("h_q_empty", 64'd1, 64'd0);
        else chk("rd_h_row", rd_h_row, h_q.pop_front());
      end
      if (a_q.size() == 0) chk("a_q_empty", 64'd1, 64'd0);
      else chk("rd_a_col", rd_a_col, a_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    H_row = '0;
    H_row_tvalid = 1'b0;
    H_row_tlast = 1'b0;
    alpha_u_col = '0;
    alpha_u_col_tvalid = 1'b0;
    alpha_u_col_tlast = 1'b0;
    rd_h_idx = '0;
    rd_a_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_errs", {err_h_last, err_a_last}, 0);
    chk("rst_treadys", {H_row_tready, alpha_u_col_tready}, 0);
    chk("rst_rd_h", rd_h_row, 0);
    chk("rst_rd_a", rd_a_col, 0);
`ifdef RX_STATS_EN
    chk("rst_stats", {stat_cycles, stat_stalls}, 0);
`endif

    // Clean frame with one 2-cycle gap per stream
    arm_pulse();
    chk("arm_busy", busy, 1);
    fork
      send_h(I, I - 1, 2, 0);
      send_a(J, J - 1, 5, 0);
    join
    wait_done();
    chk("clean_err_h", err_h_last, 0);
    chk("clean_err_a", err_a_last, 0);
`ifdef RX_STATS_EN
    chk("stat_stalls", stat_stalls, 4);
    chk("stat_cycles", stat_cycles, 16);
`endif
    readback_all();
    rd_h_idx = 4'd3;
    rd_a_idx = 5'd5;
    @(negedge clk);
    chk("rd_h3", rd_h_row, 14'h0008);
    chk("rd_a5", rd_a_col, 32'h0005_FFFB);

    // Skewed: whole alpha stream first, random gaps
    arm_pulse();
    send_a(J, J - 1, -1, 3);
    chk("skew_a_rdy_low", alpha_u_col_tready, 0);
    chk("skew_busy", busy, 1);
    chk("skew_no_done", frame_done, 0);
    chk("skew_h_rdy", H_row_tready, 1);
    send_h(I, I - 1, -1, 3);
    wait_done();
    chk("skew_errs", {err_h_last, err_a_last}, 0);
    readback_all();

    // Framing errors on both streams
    arm_pulse();
    chk("arm_clears_valid", frame_valid, 0);
    fork
      send_h(I, 4, -1, 1);
      send_a(J, -1, -1, 1);
    join
    wait_done();
    chk("ferr_h", err_h_last, 1);
    chk("ferr_a", err_a_last, 1);
    readback_all();

    // Reset in the middle of a frame
    arm_pulse();
    send_h(3, I - 1, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_treadys", {H_row_tready, alpha_u_col_tready}, 0);
    chk("mid_rst_valid", frame_valid, 0);
    chk("mid_rst_rd_h", rd_h_row, 0);
    h_q.delete();
    a_q.delete();
    arm_pulse();
    fork
      send_h(I, I - 1, -1, 0);
      send_a(J, J - 1, -1, 0);
    join
    wait_done();
    readback_all();

    // Re-arm from DONE, then out-of-range reads
    arm_pulse();
    chk("rearm_valid", frame_valid, 0);
    chk("rearm_busy", busy, 1);
    chk("rearm_errs", {err_h_last, err_a_last}, 0);
    rd_h_idx = 4'd7;
    rd_a_idx = 5'd14;
    @(negedge clk);
    chk("oor_h", rd_h_row, 0);
    chk("oor_a", rd_a_col, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/h_alpha_stream_rx.md
Name: h_alpha_stream_rx

Overview:
- Receive-side endpoint for the H_row and alpha_u_col valid/ready/last streams that the case-2 top produces.
- Captures one frame: I rows of H (J bits each) and J alpha_u columns (A signed words each).
- Checks tlast framing on both streams, then holds the frame for indexed readback by downstream logic.
- Lets the case-2 top run against a real consumer with back-pressure.

Parameters:
- J, 14, number of H columns = number of alpha_u columns per frame
- I, 7, number of H rows per frame
- A, 2, alpha_u words per column
- ALPHA_W, 16, bits per alpha_u word (two's complement)
- Derived (localparam): J_WIDTH = $clog2(J)+1; I_WIDTH = $clog2(I)+1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  one-cycle pulse; opens a new frame
- H_row  in  J  H row data
- H_row_tvalid  in  1  row beat valid
- H_row_tlast  in  1  marks row I-1
- H_row_tready  out  1  row beat accepted when tvalid&tready
- alpha_u_col  in  A*ALPHA_W  column data; word k at bits [k*ALPHA_W +: ALPHA_W]
- alpha_u_col_tvalid  in  1  column beat valid
- alpha_u_col_tlast  in  1  marks column J-1
- alpha_u_col_tready  out  1  column beat accepted when tvalid&tready
- busy  out  1  high in RECV
- frame_done  out  1  one-cycle pulse on entry to DONE
- frame_valid  out  1  stored frame complete and readable
- err_h_last  out  1  sticky H tlast framing error
- err_a_last  out  1  sticky alpha tlast framing error
- rd_h_idx  in  I_WIDTH  H row read index
- rd_h_row  out  J  registered H row read data
- rd_a_idx  in  J_WIDTH  alpha column read index
- rd_a_col  out  A*ALPHA_W  registered alpha column read data

Behaviour:
- Reset (rst=1 at posedge):
  - state <= IDLE; both beat counters, err_*, frame_done, frame_valid, rd_* outputs <= 0.
  - Storage arrays are not cleared; frame_valid=0 marks them invalid.
  - Reset wins over every other input, including mid-frame; the partial frame is discarded.
- FSM, three states:
  - IDLE: both treadys 0. arm -> RECV; this clears both counters and err_*. Beats presented in the same cycle as arm are not accepted.
  - RECV: busy=1.
    - H_row_tready = (h_cnt < I). alpha_u_col_tready = (a_cnt < J).
    - The two streams are fully independent and may complete in either order or in the same cycle.
    - Accepted H beat: store at row h_cnt; h_cnt += 1.
    - Accepted alpha beat: store at column a_cnt; a_cnt += 1.
    - Once h_cnt==I and a_cnt==J (counts taken after this cycle's beats) -> DONE next cycle.
  - DONE: frame_done=1 for the first cycle only; frame_valid=1 and treadys=0 throughout. arm -> RECV; frame_valid drops to 0 in that same transition.
- arm while in RECV is ignored.
- Framing check, done per accepted beat:
  - H: tlast=1 while h_cnt!=I-1, or tlast=0 while h_cnt==I-1 -> err_h_last <= 1.
  - Alpha: the same rule against J-1 sets err_a_last.
  - A frame always terminates on the counts, never on tlast. Errors are sticky until the next arm or rst.
- Readback: 1-cycle latency. rd_h_row <= Hmem[rd_h_idx]; rd_a_col <= Amem[rd_a_idx].
  - Index >= I (resp. >= J) returns all zeros.
  - Readback works in any state; data is meaningful only while frame_valid=1.
- Data is stored bit-exact; no arithmetic on the payload. Counters are I_WIDTH/J_WIDTH bits wide and never wrap: they saturate at I/J because tready drops.

Optional Feature:
- Macro RX_STATS_EN.
- Defined:
  - Adds outputs stat_cycles (16 bits): cycles spent in RECV for the last frame, saturating at 0xFFFF.
  - Adds stat_stalls (16 bits): RECV cycles in which a tready was 1 and its tvalid was 0, summed over both streams, saturating.
  - Both reset on rst and on arm, and hold their values in DONE.
- Not defined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package case2_stream_pkg:
  - Default values for J, I, A and ALPHA_W.
  - Width localparams J_WIDTH, I_WIDTH.
  - rx_state_t enum {IDLE, RECV, DONE}.
  - Typedefs h_row_t [J-1:0] and alpha_col_t [A*ALPHA_W-1:0].
- One natural sub-module, stream_frame_sink, instantiated twice (H, alpha):
  - Parameterised by beat count and data width.
  - Owns counter, tready, storage, tlast check and readback register.
  - The top keeps the FSM and the shared arm/done logic.

Test Plan:
- Clean frame: arm, then 7 H rows 0x0001<<r and 14 alpha cols {16'(c),16'(-c)} with tready honoured and tlast only on the last beats -> frame_done pulses once; rd_h_idx=3 returns 0x0008; rd_a_idx=5 returns 0x0005_FFFB; err_*=0.
- Skewed streams: all 14 alpha beats before the first H beat; random tvalid gaps -> alpha_u_col_tready drops after beat 14; done only after the 7th H row; stored data correct.
- Framing errors: H tlast on row 4 and no alpha tlast on column 13 -> err_h_last=1, err_a_last=1; frame still completes at 7/14 beats.
- Reset mid-frame: rst after 3 H rows -> next cycle state IDLE, treadys 0, frame_valid 0; a following clean frame reads back correctly.
- Re-arm and out-of-range read: arm in DONE -> frame_valid falls; rd_h_idx=7 and rd_a_idx=14 return 0.
- With RX_STATS_EN: one 2-cycle gap on each stream in the clean frame -> stat_stalls=4; stat_cycles equals the measured number of RECV cycles.
